fetch: RTL

Instruction-fetch stage of the five-stage MIPS pipeline. It owns the program counter, drives the instruction-memory read address, and loads the IF/ID pipeline register (`pc_if_id`, `ir_if_id`, `valid_if_id`) that the decode stage consumes. It honours stall, flush and PC-redirect requests from the hazard and branch logic. It traps misaligned redirect targets into a halted fault state.

---
 rtl/fetch.sv | 108 ++++++++++
 1 files changed

// File: rtl/fetch.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory address and
// loads the IF/ID register; a misaligned redirect target halts fetch in FAULT.
module fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP      = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] pc_if_id,
    output logic [31:0] ir_if_id,
    output logic        valid_if_id,
    output logic        fault,
    output logic [31:0] fault_pc
);

    // state | meaning
    // RUN   | normal fetch, honours redirect/stall/flush
    // FAULT | misaligned redirect trapped; PC frozen, bubbles only
    typedef enum logic {RUN, FAULT} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_if_id_q, pc_if_id_d;
    logic [31:0] ir_if_id_q, ir_if_id_d;
    logic        valid_q, valid_d;
    logic        fault_q, fault_d;
    logic [31:0] fault_pc_q, fault_pc_d;
    logic [31:0] pc_plus4;
    logic        misaligned;

    assign pc_plus4   = pc_q + 32'd4;
    assign misaligned = redirect && (redirect_pc[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= RUN;
            pc_q       <= RESET_PC;
            pc_if_id_q <= 32'd0;
            ir_if_id_q <= NOP;
            valid_q    <= 1'b0;
            fault_q    <= 1'b0;
            fault_pc_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pc_if_id_q <= pc_if_id_d;
            ir_if_id_q <= ir_if_id_d;
            valid_q    <= valid_d;
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pc_if_id_d = pc_if_id_q;
        ir_if_id_d = ir_if_id_q;
        valid_d    = valid_q;
        fault_d    = fault_q;
        fault_pc_d = fault_pc_q;
        case (state_q)
            RUN: begin
                if (redirect) begin
                    if (misaligned) begin
                        state_d    = FAULT;
                        fault_d    = 1'b1;
                        fault_pc_d = redirect_pc;
                    end else begin
                        pc_d = redirect_pc;
                    end
                end else if (!stall) begin
                    pc_d = pc_plus4;
                end
                // The trapping redirect also bubbles IF/ID, ahead of flush/stall.
                if (misaligned || flush) begin
                    ir_if_id_d = NOP;
                    pc_if_id_d = 32'd0;
                    valid_d    = 1'b0;
                end else if (!stall) begin
                    ir_if_id_d = imem_data;
                    pc_if_id_d = pc_plus4;
                    valid_d    = 1'b1;
                end
            end
            FAULT: begin
                ir_if_id_d = NOP;
                pc_if_id_d = 32'd0;
                valid_d    = 1'b0;
            end
            default: state_d = RUN;
        endcase
    end

    assign imem_addr   = pc_q;
    assign pc_if_id    = pc_if_id_q;
    assign ir_if_id    = ir_if_id_q;
    assign valid_if_id = valid_q;
    assign fault       = fault_q;
    assign fault_pc    = fault_pc_q;

endmodule
